// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// FSM state encoding, legal byte-lane patterns and the lane legality check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_t;

  localparam logic [3:0] LANE_W  = 4'b1111;
  localparam logic [3:0] LANE_H0 = 4'b0011;
  localparam logic [3:0] LANE_H1 = 4'b1100;
  localparam logic [3:0] LANE_B0 = 4'b0001;

  // A lane pattern is legal when it is a naturally aligned word, halfword or byte.
  function automatic logic lane_ok(input logic [3:0] pattern, input logic [1:0] addrLo);
    logic ok;
    ok = 1'b0;
    case (pattern)
      LANE_W:  ok = (addrLo == 2'b00);
      LANE_H0: ok = (addrLo == 2'b00);
      LANE_H1: ok = (addrLo == 2'b10);
      default: ok = (pattern == (LANE_B0 << addrLo));
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// M-stage data-port bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
  logic        req_en;
  logic [31:0] addr;
  logic [3:0]  ren;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        cancel;
  logic [31:0] rdata;
  logic        rvalid;
  logic        stall_req;
  logic        addr_err;

  modport master (
    output req_en, addr, ren, wen, wdata, cancel,
    input  rdata, rvalid, stall_req, addr_err
  );

  modport slave (
    input  req_en, addr, ren, wen, wdata, cancel,
    output rdata, rvalid, stall_req, addr_err
  );
endinterface

// File: rtl/dmem_array.sv
// Data SRAM model: four byte-wide banks with per-lane synchronous write and
// combinational word read. Contents are intentionally not reset.
module dmem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  for (genvar lane = 0; lane < 4; lane++) begin : gBank
    logic [7:0] bank [DEPTH];

    // Byte lane write, only when this lane is enabled.
    always_ff @(posedge clk) begin
      if (we[lane]) begin
        bank[addr] <= wdata[8*lane +: 8];
      end
    end

    assign rdata[8*lane +: 8] = bank[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port.
// Accepts one byte-enabled load/store at a time, answers after a fixed latency,
// holds the pipeline via stall_req while busy and flags illegal lane patterns.
// Optional feature macro: DMEM_WAIT_EN adds WAIT_CYCLES wait states (WAIT state
// plus down-counter); without it every request answers in the next cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  dmemState_t        stateR;
  dmemState_t        nextStateS;
  logic [ADDR_W-1:0] wordAddrR;
  logic [3:0]        wenR;
  logic [31:0]       wdataR;
  logic              laneOkR;
  logic [31:0]       rdataR;

  logic              acceptS;
  logic              respS;
  logic              writeS;
  logic [3:0]        patternS;
  logic [3:0]        laneWeS;
  logic [31:0]       arrayWordS;
  logic [31:0]       respWordS;

`ifdef DMEM_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  logic [3:0] waitCntR;
`endif

  // New requests only start from IDLE; a flush in the same cycle blocks them.
  assign acceptS  = (stateR == IDLE) && bus.req_en && ((bus.ren | bus.wen) != 4'b0000) && !bus.cancel;
  assign patternS = (bus.wen != 4'b0000) ? bus.wen : bus.ren;
  assign respS    = (stateR == RESP) && !bus.cancel;
  assign writeS   = respS && laneOkR && (wenR != 4'b0000);
  assign laneWeS  = writeS ? wenR : 4'b0000;
  // Illegal requests answer with zero; writes return the word as it was before the store.
  assign respWordS = laneOkR ? arrayWordS : 32'd0;

  // Next-state decode for the request FSM.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
`ifdef DMEM_WAIT_EN
          nextStateS = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
          nextStateS = RESP;
`endif
        end else begin
          nextStateS = IDLE;
        end
      end
      WAIT: begin
`ifdef DMEM_WAIT_EN
        if (bus.cancel) begin
          nextStateS = IDLE;
        end else if (waitCntR == 4'd0) begin
          nextStateS = RESP;
        end else begin
          nextStateS = WAIT;
        end
`else
        nextStateS = IDLE;
`endif
      end
      RESP:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // FSM state register; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

`ifdef DMEM_WAIT_EN
  // Wait-state down-counter, loaded on acceptance and run down while in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCntR <= 4'd0;
    end else if (acceptS) begin
      waitCntR <= WAIT_LOAD;
    end else if ((stateR == WAIT) && (waitCntR != 4'd0)) begin
      waitCntR <= waitCntR - 4'd1;
    end else begin
      waitCntR <= waitCntR;
    end
  end
`endif

  // Capture the request on acceptance; lane legality is decided up front.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordAddrR <= '0;
      wenR      <= 4'b0000;
      wdataR    <= 32'd0;
      laneOkR   <= 1'b0;
    end else if (acceptS) begin
      wordAddrR <= bus.addr[ADDR_W+1:2];
      wenR      <= bus.wen;
      wdataR    <= bus.wdata;
      laneOkR   <= lane_ok(patternS, bus.addr[1:0]);
    end else begin
      wordAddrR <= wordAddrR;
      wenR      <= wenR;
      wdataR    <= wdataR;
      laneOkR   <= laneOkR;
    end
  end

  // Remember the last delivered response so rdata holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdataR <= 32'd0;
    end else if (respS) begin
      rdataR <= respWordS;
    end else begin
      rdataR <= rdataR;
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) uArray (
    .clk   (clk),
    .we    (laneWeS),
    .addr  (wordAddrR),
    .wdata (wdataR),
    .rdata (arrayWordS)
  );

  // Response pulses come straight from the RESP state so a flush can still kill them.
  assign bus.rvalid    = respS;
  assign bus.addr_err  = respS && !laneOkR;
  assign bus.rdata     = respS ? respWordS : rdataR;
  // Stall drops in RESP so the pipeline advances on the response edge.
  assign bus.stall_req = rst && (acceptS || (stateR == WAIT));

endmodule
